// File: rtl/half_adder_pkg.sv
// Purpose : shared types and defaults for the half-adder cell and its wrappers.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   CNT_W_DEFAULT - default width of the carry-event counter
//   ha_result_t   - {carry, sum}, which read as a 2-bit number is exactly a + b
package half_adder_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef struct packed {
        logic carry;
        logic sum;
    } ha_result_t;

endpackage : half_adder_pkg

// File: rtl/ha_cell.sv
// Purpose : single-bit half adder; the reusable leaf cell for ripple adders and incrementers.
// Latency : zero cycles, pure combinational, no state.
// Backpressure: none; outputs follow a/b continuously.
//
// Ports:
//   a, b  - addend bits
//   sum   - a XOR b
//   carry - a AND b
module ha_cell
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    ha_result_t res;

    // Plain gates only, so X/Z on an input propagates exactly as gate
    // semantics dictate; nothing here masks an unknown.
    assign res.sum   = a ^ b;
    assign res.carry = a & b;

    assign sum   = res.sum;
    assign carry = res.carry;

endmodule : ha_cell

// File: rtl/student_half_adder.sv
// Purpose : half adder with a combinational result plus a registered copy and a saturating carry-event count.
// Latency : sum/carry zero cycles; sum_q/carry_q/carry_cnt one clk edge after the sampled a/b.
// Backpressure: none; the counter holds at all-ones instead of wrapping.
//
// Ports:
//   clk, rst_n - clock and async active-low reset for the registered path only
//   a, b       - addend bits
//   sum, carry - combinational result, independent of clk/rst_n
//   sum_q      - sum registered on clk
//   carry_q    - carry registered on clk
//   carry_cnt  - saturating count of edges that sampled carry = 1
module student_half_adder
    import half_adder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ha_result_t res;
    logic       cnt_at_max;

    // One cell feeds both the external combinational outputs and the flops,
    // so the registered copy can never disagree with what was presented.
    ha_cell u_ha_cell (
        .a     (a),
        .b     (b),
        .sum   (res.sum),
        .carry (res.carry)
    );

    assign sum   = res.sum;
    assign carry = res.carry;

    assign cnt_at_max = (carry_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= 1'b0;
            carry_q   <= 1'b0;
            carry_cnt <= '0;
        end else begin
            sum_q   <= res.sum;
            carry_q <= res.carry;
            // Stick at all-ones once reached; a wrapped count would
            // misreport a busy carry chain as an idle one.
            if (res.carry && !cnt_at_max) begin
                carry_cnt <= carry_cnt + CNT_W'(1);
            end
        end
    end

endmodule : student_half_adder

// File: tb/tb_student_half_adder.sv
// Purpose : self-checking bench for student_half_adder (8-bit and 2-bit counters, plus a free-running combinational instance).
// Latency : checks registered outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_student_half_adder;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       ac;
    logic       bc;

    wire        clk_x;
    wire        rst_x;
    assign clk_x = 1'bx;
    assign rst_x = 1'bx;

    logic       sum8, carry8, sum_q8, carry_q8;
    logic [7:0] cnt8;
    logic       sum2, carry2, sum_q2, carry_q2;
    logic [1:0] cnt2;
    logic       sumc, carryc, sum_qc, carry_qc;
    logic [7:0] cntc;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the registered side should hold.
    int m_sum_q;
    int m_carry_q;
    int m_cnt8;
    int m_cnt2;

    student_half_adder #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8), .carry_cnt(cnt8)
    );

    student_half_adder #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .sum(sum2), .carry(carry2), .sum_q(sum_q2), .carry_q(carry_q2), .carry_cnt(cnt2)
    );

    // Clock and reset deliberately unknown: the combinational result must not care.
    student_half_adder u_comb (
        .clk(clk_x), .rst_n(rst_x), .a(ac), .b(bc),
        .sum(sumc), .carry(carryc), .sum_q(sum_qc), .carry_q(carry_qc), .carry_cnt(cntc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected register contents from arithmetic: a+b split into high/low bit,
    // counters add the high bit and clip at 2^W-1.
    task automatic model_edge();
        int s;
        s = int'(a) + int'(b);
        m_sum_q   = s % 2;
        m_carry_q = s / 2;
        m_cnt8    = (m_cnt8 + s / 2 > 255) ? 255 : m_cnt8 + s / 2;
        m_cnt2    = (m_cnt2 + s / 2 > 3)   ? 3   : m_cnt2 + s / 2;
    endtask

    task automatic chk_comb(input string tag);
        int s;
        s = int'(a) + int'(b);
        chk({tag, "_sum8"},   32'(sum8),   32'(s % 2));
        chk({tag, "_carry8"}, 32'(carry8), 32'(s / 2));
        chk({tag, "_sum2"},   32'(sum2),   32'(s % 2));
        chk({tag, "_carry2"}, 32'(carry2), 32'(s / 2));
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_sum_q"},   32'(sum_q8),   32'(m_sum_q));
        chk({tag, "_carry_q"}, 32'(carry_q8), 32'(m_carry_q));
        chk({tag, "_cnt8"},    32'(cnt8),     32'(m_cnt8));
        chk({tag, "_sum_q2"},  32'(sum_q2),   32'(m_sum_q));
        chk({tag, "_cnt2"},    32'(cnt2),     32'(m_cnt2));
    endtask

    // Advance one rising edge; return 1 time unit later for sampling.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    // Reset pulse placed between edges (caller is 1 unit after an edge).
    task automatic pulse_reset();
        rst_n = 1'b0;
        m_sum_q = 0; m_carry_q = 0; m_cnt8 = 0; m_cnt2 = 0;
        #1;
        chk_regs("rst_pulse");
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a = 1'b0; b = 1'b0; ac = 1'b0; bc = 1'b0;
        m_sum_q = 0; m_carry_q = 0; m_cnt8 = 0; m_cnt2 = 0;

        // Exhaustive truth table on the instance with X clock/reset.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] p;
            p = 2'(i);
            ac = p[1]; bc = p[0];
            #1;
            chk($sformatf("comb_%0d_sum", i),   32'(sumc),   32'((i / 2 + i % 2) % 2));
            chk($sformatf("comb_%0d_carry", i), 32'(carryc), 32'((i / 2 + i % 2) / 2));
        end

        // Reset state, held across edges.
        #1;
        chk_regs("reset");
        tick(); tick();
        chk_regs("reset_held");
        rst_n = 1'b1;
        #1;

        // Registered latency.
        a = 1'b1; b = 1'b1;
        #1;
        chk_comb("lat11");
        chk("lat_before_carry_q", 32'(carry_q8), 32'd0);
        tick();
        chk("lat_after_carry_q", 32'(carry_q8), 32'd1);
        chk("lat_after_sum_q",   32'(sum_q8),   32'd0);
        a = 1'b1; b = 1'b0;
        tick();
        chk("lat2_sum_q",   32'(sum_q8),   32'd1);
        chk("lat2_carry_q", 32'(carry_q8), 32'd0);
        chk_regs("lat2");

        // Counter: five carry edges, then three idle edges.
        pulse_reset();
        a = 1'b1; b = 1'b1;
        repeat (5) tick();
        chk("cnt_five",     32'(cnt8), 32'd5);
        chk("cnt2_clipped", 32'(cnt2), 32'd3);
        a = 1'b0;
        repeat (3) tick();
        chk("cnt_hold", 32'(cnt8), 32'd5);
        chk_regs("cnt");

        // Saturation on the 2-bit counter.
        pulse_reset();
        a = 1'b1; b = 1'b1;
        repeat (6) tick();
        chk("sat_cnt2", 32'(cnt2), 32'd3);
        chk("sat_cnt8", 32'(cnt8), 32'd6);

        // Async reset mid-count.
        pulse_reset();
        repeat (4) tick();
        chk("mid_cnt4", 32'(cnt8), 32'd4);
        rst_n = 1'b0;
        m_sum_q = 0; m_carry_q = 0; m_cnt8 = 0; m_cnt2 = 0;
        #1;
        chk("async_sum_q",   32'(sum_q8),   32'd0);
        chk("async_carry_q", 32'(carry_q8), 32'd0);
        chk("async_cnt",     32'(cnt8),     32'd0);
        chk_comb("async11");
        a = 1'b0;
        #1;
        chk_comb("async01");
        tick();
        chk_regs("async_held");

        // Release with a=b=1 between edges: first count on the next edge.
        a = 1'b1; b = 1'b1;
        #2;
        rst_n = 1'b1;
        #1;
        chk("rel_before", 32'(cnt8), 32'd0);
        tick();
        chk("rel_first", 32'(cnt8), 32'd1);

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) pulse_reset();
            #1;
            chk_comb("rnd");
            tick();
            chk_regs("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_student_half_adder
